// File: rtl/snn_readout_pkg.sv
// rtl/snn_readout_pkg.sv - shared state encoding and default sizing for the spike-count readout
package snn_readout_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SCAN  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int N_DEF      = 96;
  localparam int WINDOW_DEF = 50;
  localparam int CW_DEF     = 8;

endpackage

// File: rtl/snn_readout_argmax.sv
// rtl/snn_readout_argmax.sv - sequential argmax, one neuron per cycle, strict compare so lowest index wins ties
module snn_readout_argmax
  import snn_readout_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    clr,
  input  logic                    start,
  input  logic [N-1:0][CW-1:0]    counts,
  output logic                    done,
  output logic [$clog2(N)-1:0]    idx,
  output logic [CW-1:0]           best_count
);

  localparam int IW = $clog2(N);

  logic          r_busy;
  logic [IW-1:0] r_i;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_best;
  logic          w_last;

  assign w_last = (r_i == IW'(N - 1));

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_busy <= 1'b0;
      r_i    <= '0;
      r_idx  <= '0;
      r_best <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_i    <= '0;
      r_idx  <= '0;
      r_best <= '0;
    end else if (r_busy) begin
      if (counts[r_i] > r_best) begin
        r_best <= counts[r_i];
        r_idx  <= r_i;
      end
      if (w_last) begin
        r_busy <= 1'b0;
        r_i    <= '0;
      end else begin
        r_i <= r_i + IW'(1);
      end
    end
  end

  assign done       = r_busy && w_last;
  assign idx        = r_idx;
  assign best_count = r_best;

endmodule

// File: rtl/snn_readout.sv
// rtl/snn_readout.sv - windowed spike counter with argmax classification; SNN_READOUT_COUNT_OUT_EN adds cls_count
module snn_readout
  import snn_readout_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int WINDOW = WINDOW_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 step_valid,
  input  logic [N-1:0]         spikes_vec,
  output logic                 step_ready,
  input  logic                 flush,
  output logic                 cls_valid,
  input  logic                 cls_ready,
  output logic [$clog2(N)-1:0] cls_idx,
  output logic                 cls_none
`ifdef SNN_READOUT_COUNT_OUT_EN
  ,
  output logic [CW-1:0]        cls_count
`endif
);

  localparam int          IW        = $clog2(N);
  localparam logic [15:0] LAST_STEP = 16'(WINDOW - 1);

  state_t               r_state;
  state_t               w_next;
  logic [N-1:0][CW-1:0] r_cnt;
  logic [15:0]          r_step;
  logic                 w_accept;
  logic                 w_last;
  logic                 w_take;
  logic                 w_done;
  logic                 w_scan_clr;
  logic [IW-1:0]        w_best_idx;
  logic [CW-1:0]        w_best_cnt;

  assign step_ready = (r_state == ACCUM);
  assign w_accept   = step_valid && step_ready;
  assign w_last     = (r_step == LAST_STEP);
  assign w_take     = (r_state == HOLD) && cls_ready;
  assign w_scan_clr = flush || w_take;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ACCUM;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ACCUM:   if (w_accept && w_last) w_next = SCAN;
      SCAN:    if (w_done) w_next = HOLD;
      HOLD:    if (cls_ready) w_next = ACCUM;
      default: w_next = ACCUM;
    endcase
    if (flush) w_next = ACCUM;
  end

  // Counts saturate at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      r_cnt  <= '0;
      r_step <= '0;
    end else if (w_take) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      for (int n = 0; n < N; n++) begin
        if (spikes_vec[n] && (r_cnt[n] != {CW{1'b1}}))
          r_cnt[n] <= r_cnt[n] + CW'(1);
      end
      r_step <= w_last ? 16'd0 : r_step + 16'd1;
    end
  end

  snn_readout_argmax #(.N(N), .CW(CW)) u_argmax (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (w_scan_clr),
    .start      (w_accept && w_last),
    .counts     (r_cnt),
    .done       (w_done),
    .idx        (w_best_idx),
    .best_count (w_best_cnt)
  );

  assign cls_valid = (r_state == HOLD);
  assign cls_idx   = w_best_idx;
  assign cls_none  = (r_state == HOLD) && (w_best_cnt == '0);
`ifdef SNN_READOUT_COUNT_OUT_EN
  assign cls_count = w_best_cnt;
`endif

endmodule

// File: tb/tb_snn_readout.sv
// tb/tb_snn_readout.sv - directed bench for snn_readout (N=12, WINDOW=4, CW=2)
module tb_snn_readout;

  localparam int N      = 12;
  localparam int WINDOW = 4;
  localparam int CW     = 2;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         step_valid = 1'b0;
  logic [N-1:0] spikes_vec = '0;
  logic         flush = 1'b0;
  logic         cls_ready = 1'b0;
  logic         step_ready;
  logic         cls_valid;
  logic [3:0]   cls_idx;
  logic         cls_none;
`ifdef SNN_READOUT_COUNT_OUT_EN
  logic [CW-1:0] cls_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  snn_readout #(.N(N), .WINDOW(WINDOW), .CW(CW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .step_valid (step_valid),
    .spikes_vec (spikes_vec),
    .step_ready (step_ready),
    .flush      (flush),
    .cls_valid  (cls_valid),
    .cls_ready  (cls_ready),
    .cls_idx    (cls_idx),
    .cls_none   (cls_none)
`ifdef SNN_READOUT_COUNT_OUT_EN
    ,
    .cls_count  (cls_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] s);
    step_valid = 1'b1;
    spikes_vec = s;
    tick();
    step_valid = 1'b0;
    spikes_vec = '0;
  endtask

  task automatic send_window(input logic [N-1:0] s0, input logic [N-1:0] s1,
                             input logic [N-1:0] s2, input logic [N-1:0] s3);
    send(s0);
    send(s1);
    send(s2);
    send(s3);
  endtask

  task automatic wait_valid(input string tag);
    int c;
    c = 0;
    while (cls_valid !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
    chk(tag, c, N);
  endtask

  task automatic handshake();
    cls_ready = 1'b1;
    tick();
    cls_ready = 1'b0;
  endtask

  initial begin
    int seen;

    tick();
    tick();
    chk("rst_valid", cls_valid, 0);
    chk("rst_idx", cls_idx, 0);
    chk("rst_none", cls_none, 0);
`ifdef SNN_READOUT_COUNT_OUT_EN
    chk("rst_count", cls_count, 0);
`endif
    rstn = 1'b1;
    tick();
    chk("rst_ready", step_ready, 1);

    send_window(12'h080, 12'h080, 12'h080, 12'h080);
    chk("scan_ready_low", step_ready, 0);
    wait_valid("lat_n7");
    chk("n7_idx", cls_idx, 7);
    chk("n7_none", cls_none, 0);
`ifdef SNN_READOUT_COUNT_OUT_EN
    chk("n7_count_sat", cls_count, 3);
`endif
    handshake();
    chk("n7_ack_valid", cls_valid, 0);
    chk("n7_ack_ready", step_ready, 1);

    send_window(12'h408, 12'h002, 12'h008, 12'h400);
    wait_valid("lat_tie");
    chk("tie_idx", cls_idx, 3);
    chk("tie_none", cls_none, 0);
    handshake();

    send_window(12'h024, 12'h024, 12'h020, 12'h020);
    wait_valid("lat_sat");
    chk("sat_idx", cls_idx, 5);
`ifdef SNN_READOUT_COUNT_OUT_EN
    chk("sat_count", cls_count, 3);
`endif
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", cls_valid, 1);
      chk("hold_idx", cls_idx, 5);
      chk("hold_none", cls_none, 0);
      chk("hold_ready", step_ready, 0);
    end
    cls_ready = 1'b1;
    tick();
    cls_ready = 1'b0;
    chk("hold_ack_ready", step_ready, 1);
    chk("hold_ack_valid", cls_valid, 0);

    send_window('0, '0, '0, '0);
    wait_valid("lat_zero");
    chk("zero_none", cls_none, 1);
    chk("zero_idx", cls_idx, 0);

    flush = 1'b1;
    cls_ready = 1'b1;
    tick();
    flush = 1'b0;
    cls_ready = 1'b0;
    chk("flush_ack_valid", cls_valid, 0);
    chk("flush_ack_ready", step_ready, 1);

    send(12'h010);
    send(12'h010);
    flush = 1'b1;
    step_valid = 1'b1;
    spikes_vec = 12'h008;
    tick();
    flush = 1'b0;
    step_valid = 1'b0;
    spikes_vec = '0;
    chk("flush_ready", step_ready, 1);
    send(12'h100);
    send('0);
    send('0);
    chk("flush_step3_ready", step_ready, 1);
    send('0);
    chk("flush_scan_ready", step_ready, 0);
    wait_valid("lat_flush");
    chk("flush_idx", cls_idx, 8);
    handshake();

    send_window(12'h080, 12'h080, 12'h080, 12'h080);
    tick();
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < N + 4; i++) begin
      if (cls_valid === 1'b1) seen++;
      tick();
    end
    chk("rst_scan_no_valid", seen, 0);
    chk("rst_scan_ready", step_ready, 1);
    send_window(12'h800, 12'h800, 12'h800, 12'h800);
    wait_valid("lat_post_rst");
    chk("post_rst_idx", cls_idx, 11);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
